icu_core_n: RTL

- Parametrised successor to the 1-bit MC14500B-style controller.
- Executes the same 16-opcode instruction set, but on a DATA_W-bit result register (RR) with bitwise logic.
- Adds a hardware return stack for JMP/RTN, a conditional skip (SKZ), run/halt control, and a sticky stack-error flag.
- Integrates program memory, data RAM, program counter and control; it is the top-level controller instance.

---
 rtl/icu_core_n.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/icu_core_n.sv
// icu_core_n: DATA_W-bit MC14500B-style controller; ICU_STACK_EN enables the return stack and stack_err
module icu_core_n #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 4,
    parameter int CODE_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     prog_we,
    input  logic [ADDR_W-1:0]        prog_addr,
    input  logic [CODE_W+ADDR_W-1:0] prog_data,
    output logic [CODE_W-1:0]        opcode,
    output logic [DATA_W-1:0]        rr_out,
    output logic                     flag_o,
    output logic                     flag_f,
    output logic                     jmp_flag,
    output logic                     rtn_flag,
    output logic                     stack_err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int IW    = CODE_W + ADDR_W;

    typedef enum logic [CODE_W-1:0] {
        OP_NOPO, OP_LD, OP_LDC, OP_AND, OP_ANDC, OP_OR, OP_ORC, OP_XNOR,
        OP_STO, OP_STOC, OP_IEN, OP_OEN, OP_JMP, OP_RTN, OP_SKZ, OP_NOPF
    } opcode_e;

    logic [IW-1:0]     prog_mem [DEPTH];
    logic [DATA_W-1:0] ram [DEPTH];
    logic [IW-1:0]     instr;
    logic [ADDR_W-1:0] op;
    logic [DATA_W-1:0] data_in, d, ram_wd;
    logic              ram_we;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rr_q, rr_d;
    logic              ien_q, ien_d, oen_q, oen_d, skip_q, skip_d;
    logic              flag_o_q, flag_o_d, flag_f_q, flag_f_d;
    logic              jmp_q, jmp_d, rtn_q, rtn_d;
`ifdef ICU_STACK_EN
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    logic [ADDR_W-1:0] stack_mem [2 ** SP_W];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              stack_err_q, stack_err_d, push_we;
`else
    logic unused_depth;
    assign unused_depth = ^STACK_DEPTH;
`endif

    assign instr   = prog_mem[pc_q];
    assign opcode  = instr[IW-1 -: CODE_W];
    assign op      = instr[ADDR_W-1:0];
    // The all-ones operand addresses RR itself rather than a RAM cell
    assign data_in = (&op) ? rr_q : ram[op];
    assign d       = ien_q ? data_in : '0;
    assign rr_out  = rr_q;
    assign flag_o  = flag_o_q;
    assign flag_f  = flag_f_q;
    assign jmp_flag = jmp_q;
    assign rtn_flag = rtn_q;
`ifdef ICU_STACK_EN
    assign stack_err = stack_err_q;
`else
    assign stack_err = 1'b0;
`endif

    // Next-state decode: halt holds everything, a pending skip only advances PC
    always_comb begin
        pc_d = pc_q;
        rr_d = rr_q;
        ien_d = ien_q;
        oen_d = oen_q;
        skip_d = skip_q;
        flag_o_d = 1'b0;
        flag_f_d = 1'b0;
        jmp_d = 1'b0;
        rtn_d = 1'b0;
        ram_we = 1'b0;
        ram_wd = rr_q;
`ifdef ICU_STACK_EN
        sp_d = sp_q;
        stack_err_d = stack_err_q;
        push_we = 1'b0;
`endif
        if (run) begin
            pc_d = pc_q + 1'b1;
            skip_d = 1'b0;
        end
        if (run && !skip_q) begin
            case (opcode_e'(opcode))
                OP_NOPO: flag_o_d = 1'b1;
                OP_LD:   rr_d = d;
                OP_LDC:  rr_d = ~d;
                OP_AND:  rr_d = rr_q & d;
                OP_ANDC: rr_d = rr_q & ~d;
                OP_OR:   rr_d = rr_q | d;
                OP_ORC:  rr_d = rr_q | ~d;
                OP_XNOR: rr_d = ~(rr_q ^ d);
                OP_STO:  ram_we = oen_q & ~(&op);
                OP_STOC: begin
                    ram_we = oen_q & ~(&op);
                    ram_wd = ~rr_q;
                end
                OP_IEN:  ien_d = data_in[0];
                OP_OEN:  oen_d = data_in[0];
                OP_JMP: begin
                    pc_d = op;
                    jmp_d = 1'b1;
`ifdef ICU_STACK_EN
                    if (sp_q != SP_FULL) begin
                        push_we = 1'b1;
                        sp_d = sp_q + 1'b1;
                    end else begin
                        stack_err_d = 1'b1;
                    end
`endif
                end
`ifdef ICU_STACK_EN
                OP_RTN: begin
                    if (sp_q != '0) begin
                        pc_d = stack_mem[sp_q - 1'b1];
                        sp_d = sp_q - 1'b1;
                        rtn_d = 1'b1;
                    end else begin
                        stack_err_d = 1'b1;
                    end
                end
`else
                OP_RTN: begin
                    skip_d = 1'b1;
                    rtn_d = 1'b1;
                end
`endif
                OP_SKZ:  skip_d = (rr_q == '0);
                OP_NOPF: flag_f_d = 1'b1;
            endcase
        end
    end

    // Architectural state; reset aborts at once and drops any pending skip or stack contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
            rr_q <= '0;
            ien_q <= 1'b1;
            oen_q <= 1'b1;
            skip_q <= 1'b0;
            flag_o_q <= 1'b0;
            flag_f_q <= 1'b0;
            jmp_q <= 1'b0;
            rtn_q <= 1'b0;
`ifdef ICU_STACK_EN
            sp_q <= '0;
            stack_err_q <= 1'b0;
`endif
        end else begin
            pc_q <= pc_d;
            rr_q <= rr_d;
            ien_q <= ien_d;
            oen_q <= oen_d;
            skip_q <= skip_d;
            flag_o_q <= flag_o_d;
            flag_f_q <= flag_f_d;
            jmp_q <= jmp_d;
            rtn_q <= rtn_d;
`ifdef ICU_STACK_EN
            sp_q <= sp_d;
            stack_err_q <= stack_err_d;
`endif
        end
    end

    // Memories are not reset; program writes are accepted regardless of run
    always_ff @(posedge clk) begin
        if (prog_we) prog_mem[prog_addr] <= prog_data;
        if (ram_we) ram[op] <= ram_wd;
    end

`ifdef ICU_STACK_EN
    // Return address push for a JMP that still has room on the stack
    always_ff @(posedge clk) begin
        if (push_we) stack_mem[sp_q] <= pc_q + 1'b1;
    end
`endif
endmodule
